// File: rtl/i2f_pkg.sv
// Shared types and constants for the integer-to-single-precision converter.
package i2f_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int EXP_BIAS    = 127;
  localparam int EXP_INT_TOP = EXP_BIAS + 31;
  localparam int MANT_W      = 23;

endpackage

// File: rtl/i2f_round.sv
// Round-to-nearest-even of a normalised magnitude (hidden bit already stripped).
// With I2F_FLAGS_EN defined, also reports whether any discarded bit was set.
module i2f_round
  import i2f_pkg::*;
(
  input  logic [30:0]       mag,
  input  logic [7:0]        exp_in,
  output logic [7:0]        exp_out,
  output logic [MANT_W-1:0] mant
`ifdef I2F_FLAGS_EN
  ,
  output logic              inexact
`endif
);

  logic            lsb;
  logic            guard;
  logic            sticky;
  logic            inc;
  logic [MANT_W:0] sum;

  assign lsb    = mag[8];
  assign guard  = mag[7];
  assign sticky = |mag[6:0];
  assign inc    = guard && (sticky || lsb);

  // A carry out of the mantissa means 1.111..1 rounded up to 10.0, i.e. one more exponent step.
  assign sum     = {1'b0, mag[30:8]} + {{MANT_W{1'b0}}, inc};
  assign mant    = sum[MANT_W-1:0];
  assign exp_out = exp_in + {7'd0, sum[MANT_W]};

`ifdef I2F_FLAGS_EN
  assign inexact = guard | sticky;
`endif

endmodule

// File: rtl/int_to_float_conv.sv
// Multi-cycle 32-bit integer to IEEE 754 single converter with valid/ready on both sides.
// Optional out_inexact flag is built when I2F_FLAGS_EN is defined.
module int_to_float_conv
  import i2f_pkg::*;
#(
  parameter int SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_signed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
`ifdef I2F_FLAGS_EN
  ,
  output logic        out_inexact
`endif
);

  state_e            state;
  logic              sign;
  logic [31:0]       mag;
  logic [7:0]        exp_r;
  logic              neg_in;
  logic [31:0]       mag_in;
  logic              step_zero;
  logic [3:0]        shamt;
  logic [7:0]        r_exp;
  logic [MANT_W-1:0] r_mant;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // 0x80000000 signed negates to itself, which is the correct unsigned magnitude.
  assign neg_in = in_signed & in_data[31];
  assign mag_in = neg_in ? (~in_data + 32'd1) : in_data;

  assign step_zero = ~|mag[31 -: SHIFT_STEP];
  assign shamt     = step_zero ? 4'(SHIFT_STEP) : 4'd1;

`ifdef I2F_FLAGS_EN
  logic r_inexact;

  i2f_round u_round (
    .mag     (mag[30:0]),
    .exp_in  (exp_r),
    .exp_out (r_exp),
    .mant    (r_mant),
    .inexact (r_inexact)
  );
`else
  i2f_round u_round (
    .mag     (mag[30:0]),
    .exp_in  (exp_r),
    .exp_out (r_exp),
    .mant    (r_mant)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sign     <= 1'b0;
      mag      <= 32'd0;
      exp_r    <= 8'd0;
      out_data <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign  <= neg_in;
            mag   <= mag_in;
            exp_r <= 8'(EXP_INT_TOP);
            if (mag_in == 32'd0) begin
              out_data <= 32'd0;
              state    <= DONE;
            end else begin
              state <= NORM;
            end
          end
        end
        NORM: begin
          if (mag[31]) begin
            state <= ROUND;
          end else begin
            mag   <= mag << shamt;
            exp_r <= exp_r - {4'd0, shamt};
          end
        end
        ROUND: begin
          out_data <= {sign, r_exp, r_mant};
          state    <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef I2F_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_inexact <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      out_inexact <= 1'b0;
    end else if (state == ROUND) begin
      out_inexact <= r_inexact;
    end
  end
`endif

endmodule
